// File: rtl/dct_pkg.sv
// Shared constants and sample types for the 8-point DCT datapath.
// Used by both the forward and the inverse butterfly stages.
package dct_pkg;

    localparam int DCT_N  = 8;
    localparam int DCT_IW = 9;
    localparam int DCT_OW = 8;

    typedef logic signed [DCT_OW-1:0] sample_t;
    typedef logic signed [DCT_IW-1:0] bfly_t;

    localparam sample_t DCT_SMAX = {1'b0, {(DCT_OW-1){1'b1}}};
    localparam sample_t DCT_SMIN = {1'b1, {(DCT_OW-1){1'b0}}};

endpackage

// File: rtl/dct_inv_lane.sv
// One (sum, difference) pair to (x_k, x_{7-k}): round-half-up halving and
// clamp to the signed OW-bit range, with a clamp event output.
module dct_inv_lane #(
    parameter int IW = 9,
    parameter int OW = 8
) (
    input  logic signed [IW:0]   s,
    input  logic signed [IW:0]   d,
    output logic signed [OW-1:0] x_s,
    output logic signed [OW-1:0] x_d,
    output logic                 clamp
);

    localparam int WW = IW + 2;
    localparam logic signed [WW-1:0] MAXV = WW'((1 <<< (OW - 1)) - 1);
    localparam logic signed [WW-1:0] MINV = WW'(-(1 <<< (OW - 1)));
    localparam logic signed [WW-1:0] ONE  = WW'(1);

    logic signed [WW-1:0] s_h;
    logic signed [WW-1:0] d_h;
    logic                 s_hi, s_lo, d_hi, d_lo;

    // One guard bit above the IW+1 inputs keeps the +1 from overflowing
    assign s_h = (WW'(s) + ONE) >>> 1;
    assign d_h = (WW'(d) + ONE) >>> 1;

    always_comb begin
        s_hi = (s_h > MAXV);
        s_lo = (s_h < MINV);
        d_hi = (d_h > MAXV);
        d_lo = (d_h < MINV);

        x_s = s_h[OW-1:0];
        if (s_hi) x_s = MAXV[OW-1:0];
        if (s_lo) x_s = MINV[OW-1:0];

        x_d = d_h[OW-1:0];
        if (d_hi) x_d = MAXV[OW-1:0];
        if (d_lo) x_d = MINV[OW-1:0];

        clamp = s_hi | s_lo | d_hi | d_lo;
    end

endmodule

// File: rtl/dct_inv_butterfly.sv
// Inverse stage-1 butterfly: two-stage valid/ready pipeline rebuilding x0..x7.
// Optional saturation event counter enabled by DCT_INV_SAT_CNT_EN.
module dct_inv_butterfly
    import dct_pkg::*;
#(
    parameter int IW = DCT_IW,
    parameter int OW = DCT_OW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [IW-1:0] r0,
    input  logic signed [IW-1:0] r1,
    input  logic signed [IW-1:0] r2,
    input  logic signed [IW-1:0] r3,
    input  logic signed [IW-1:0] r4,
    input  logic signed [IW-1:0] r5,
    input  logic signed [IW-1:0] r6,
    input  logic signed [IW-1:0] r7,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] x0,
    output logic signed [OW-1:0] x1,
    output logic signed [OW-1:0] x2,
    output logic signed [OW-1:0] x3,
    output logic signed [OW-1:0] x4,
    output logic signed [OW-1:0] x5,
    output logic signed [OW-1:0] x6,
    output logic signed [OW-1:0] x7,
    output logic                 sat_flag
`ifdef DCT_INV_SAT_CNT_EN
    ,
    output logic [15:0]          sat_count
`endif
);

    logic signed [IW-1:0] r     [8];
    logic signed [IW:0]   s_q   [4];
    logic signed [IW:0]   d_q   [4];
    logic signed [OW-1:0] x_nxt [8];
    logic signed [OW-1:0] x_q   [8];
    logic [3:0]           clamp;
    logic                 a_valid;
    logic                 b_valid;
    logic                 b_ready;
    logic                 sat_q;

    assign r[0] = r0;
    assign r[1] = r1;
    assign r[2] = r2;
    assign r[3] = r3;
    assign r[4] = r4;
    assign r[5] = r5;
    assign r[6] = r6;
    assign r[7] = r7;

    assign b_ready  = !b_valid || out_ready;
    assign in_ready = !a_valid || b_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_valid <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                s_q[k] <= '0;
                d_q[k] <= '0;
            end
        end else begin
            if (in_ready) a_valid <= in_valid;
            if (in_valid && in_ready) begin
                for (int k = 0; k < 4; k++) begin
                    s_q[k] <= {r[k][IW-1], r[k]} + {r[7-k][IW-1], r[7-k]};
                    d_q[k] <= {r[k][IW-1], r[k]} - {r[7-k][IW-1], r[7-k]};
                end
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        dct_inv_lane #(.IW(IW), .OW(OW)) u_lane (
            .s     (s_q[k]),
            .d     (d_q[k]),
            .x_s   (x_nxt[k]),
            .x_d   (x_nxt[7-k]),
            .clamp (clamp[k])
        );
    end

    // x only loads on a real transfer so it holds through bubbles and stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_valid <= 1'b0;
            sat_q   <= 1'b0;
            for (int i = 0; i < 8; i++) x_q[i] <= '0;
        end else if (b_ready) begin
            b_valid <= a_valid;
            if (a_valid) begin
                sat_q <= |clamp;
                for (int i = 0; i < 8; i++) x_q[i] <= x_nxt[i];
            end
        end
    end

    assign out_valid = b_valid;
    assign sat_flag  = sat_q;
    assign x0 = x_q[0];
    assign x1 = x_q[1];
    assign x2 = x_q[2];
    assign x3 = x_q[3];
    assign x4 = x_q[4];
    assign x5 = x_q[5];
    assign x6 = x_q[6];
    assign x7 = x_q[7];

`ifdef DCT_INV_SAT_CNT_EN
    logic [15:0] sat_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && sat_flag && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

    assign sat_count = sat_cnt;
`endif

endmodule

// File: tb/tb_dct_inv_butterfly.sv
// Scoreboard bench for dct_inv_butterfly; DCT_INV_SAT_CNT_EN adds the counter scenario.
module tb_dct_inv_butterfly;
    import dct_pkg::*;

    localparam int IW = DCT_IW;
    localparam int OW = DCT_OW;

    typedef struct {
        logic [63:0] x;
        logic        sat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sat_flag;
    logic signed [IW-1:0] r [8];
    logic signed [OW-1:0] x [8];
`ifdef DCT_INV_SAT_CNT_EN
    logic [15:0]          sat_count;
`endif

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dct_inv_butterfly dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r0 (r[0]), .r1 (r[1]), .r2 (r[2]), .r3 (r[3]),
        .r4 (r[4]), .r5 (r[5]), .r6 (r[6]), .r7 (r[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0 (x[0]), .x1 (x[1]), .x2 (x[2]), .x3 (x[3]),
        .x4 (x[4]), .x5 (x[5]), .x6 (x[6]), .x7 (x[7]),
        .sat_flag  (sat_flag)
`ifdef DCT_INV_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    function automatic logic [63:0] pack_x();
        logic [63:0] p;
        for (int i = 0; i < DCT_N; i++) p[63-8*i -: 8] = x[i];
        return p;
    endfunction

    function automatic exp_t model(input int rv[8]);
        exp_t e;
        e.x   = '0;
        e.sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 2; j++) begin
                int v;
                int h;
                int lane;
                v    = (j == 0) ? rv[k] + rv[7-k] : rv[k] - rv[7-k];
                h    = (v + 1) >>> 1;
                lane = (j == 0) ? k : 7 - k;
                if (h > int'(DCT_SMAX)) begin
                    h = int'(DCT_SMAX);
                    e.sat = 1'b1;
                end else if (h < int'(DCT_SMIN)) begin
                    h = int'(DCT_SMIN);
                    e.sat = 1'b1;
                end
                e.x[63-8*lane -: 8] = 8'(h);
            end
        end
        return e;
    endfunction

    task automatic set_in(input logic v, input int rv[8], input logic ordy);
        in_valid = v;
        for (int i = 0; i < DCT_N; i++) r[i] = rv[i][IW-1:0];
        out_ready = ordy;
    endtask

    task automatic test_reset();
        int z[8] = '{default: 0};
        reset = 1'b0;
        set_in(1'b0, z, 1'b0);
        #2;
        n_vec++;
        if ({out_valid, sat_flag, pack_x()} !== 66'd0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b sat=%b x=%h want all zero", out_valid, sat_flag, pack_x());
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        int   vecs[5][8] = '{'{72, 0, 0, 0, 0, 0, 0, 128},
                             '{255, 0, 0, 0, 0, 0, 0, 255},
                             '{0, 0, 0, -256, -256, 0, 0, 0},
                             '{0, 3, 0, 0, 0, 0, 0, 0},
                             '{0, 0, -3, 0, 0, 0, 0, 0}};
        int   z[8] = '{default: 0};
        int   idx = 0;
        exp_t e;
        for (int c = 0; c < 40 && (idx < 5 || sb.size() > 0); c++) begin
            if (idx < 5) set_in(1'b1, vecs[idx], 1'b1);
            else         set_in(1'b0, z, 1'b1);
            #1;
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL directed_extra: output with empty scoreboard x=%h", pack_x());
                end else begin
                    e = sb.pop_front();
                    if ({pack_x(), sat_flag} !== {e.x, e.sat}) begin
                        n_err++;
                        $display("FAIL directed_data: got x=%h sat=%b want x=%h sat=%b", pack_x(), sat_flag, e.x, e.sat);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(vecs[idx]));
                idx++;
            end
            @(negedge clk);
        end
        n_vec++;
        if (idx < 5 || sb.size() != 0) begin
            n_err++;
            $display("FAIL directed_timeout: sent %0d pending %0d want 5 and 0", idx, sb.size());
        end
    endtask

    task automatic test_backpressure();
        int          cur[8];
        int          idx = 0;
        logic        held_v = 1'b0;
        logic [65:0] held = '0;
        logic        saw_full = 1'b0;
        logic        exp_rdy;
        exp_t        e;
        for (int c = 0; c < 40 && (idx < 5 || sb.size() > 0); c++) begin
            for (int i = 0; i < DCT_N; i++) cur[i] = ((idx * 37 + i * 53) % 512) - 256;
            set_in(idx < 5, cur, !(c >= 3 && c <= 6));
            #1;
            exp_rdy = (sb.size() < 2) || out_ready;
            if (!exp_rdy) saw_full = 1'b1;
            n_vec++;
            if (in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL bp_in_ready: cycle %0d got %b want %b", c, in_ready, exp_rdy);
            end
            if (held_v) begin
                n_vec++;
                if ({out_valid, sat_flag, pack_x()} !== held) begin
                    n_err++;
                    $display("FAIL bp_stable: cycle %0d got %h want %h", c, {out_valid, sat_flag, pack_x()}, held);
                end
            end
            held_v = out_valid && !out_ready;
            held   = {out_valid, sat_flag, pack_x()};
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra: output with empty scoreboard x=%h", pack_x());
                end else begin
                    e = sb.pop_front();
                    if ({pack_x(), sat_flag} !== {e.x, e.sat}) begin
                        n_err++;
                        $display("FAIL bp_data: got x=%h sat=%b want x=%h sat=%b", pack_x(), sat_flag, e.x, e.sat);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(cur));
                idx++;
            end
            @(negedge clk);
        end
        n_vec++;
        if (idx < 5 || sb.size() != 0 || !saw_full) begin
            n_err++;
            $display("FAIL bp_done: sent %0d pending %0d full %b want 5 0 1", idx, sb.size(), saw_full);
        end
    endtask

    task automatic test_random();
        int   cur[8];
        int   z[8] = '{default: 0};
        exp_t e;
        int   c = 0;
        while (c < 200 && (c < 80 || sb.size() > 0)) begin
            for (int i = 0; i < DCT_N; i++) cur[i] = int'($urandom_range(511)) - 256;
            if (c < 80) set_in(1'($urandom_range(1)), cur, 1'($urandom_range(3) != 0));
            else        set_in(1'b0, z, 1'b1);
            #1;
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_extra: output with empty scoreboard x=%h", pack_x());
                end else begin
                    e = sb.pop_front();
                    if ({pack_x(), sat_flag} !== {e.x, e.sat}) begin
                        n_err++;
                        $display("FAIL rand_data: got x=%h sat=%b want x=%h sat=%b", pack_x(), sat_flag, e.x, e.sat);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(cur));
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL rand_timeout: pending %0d want 0", sb.size());
        end
    endtask

    task automatic test_async_reset();
        int   v1[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
        int   v2[8] = '{-5, 7, -9, 11, 13, -15, 17, -19};
        int   z[8] = '{default: 0};
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, (i == 0) ? v1 : v2, 1'b0);
            @(negedge clk);
        end
        set_in(1'b0, z, 1'b0);
        #1;
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL arst_loaded: out_valid got %b want 1", out_valid);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, sat_flag, pack_x()} !== 66'd0) begin
            n_err++;
            $display("FAIL arst_clear: got valid=%b sat=%b x=%h want all zero", out_valid, sat_flag, pack_x());
        end
        #2;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            set_in(1'b0, z, 1'b1);
            #1;
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL arst_stale: cycle %0d out_valid got %b want 0", c, out_valid);
            end
            @(negedge clk);
        end
        set_in(1'b1, v2, 1'b1);
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL arst_ready: got %b want 1", in_ready);
        end
        sb.push_back(model(v2));
        @(negedge clk);
        set_in(1'b0, z, 1'b1);
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL arst_lat1: out_valid got %b want 0", out_valid);
        end
        @(negedge clk);
        #1;
        e = sb.pop_front();
        n_vec++;
        if ({out_valid, pack_x(), sat_flag} !== {1'b1, e.x, e.sat}) begin
            n_err++;
            $display("FAIL arst_lat2: got valid=%b x=%h sat=%b want 1 x=%h sat=%b", out_valid, pack_x(), sat_flag, e.x, e.sat);
        end
        @(negedge clk);
    endtask

`ifdef DCT_INV_SAT_CNT_EN
    task automatic test_sat_count();
        int   vecs[5][8] = '{'{255, 0, 0, 0, 0, 0, 0, 255},
                             '{1, 2, 3, 4, 5, 6, 7, 8},
                             '{0, 0, -256, 0, 0, -256, 0, 0},
                             '{-4, 0, 0, 0, 0, 0, 0, 4},
                             '{0, 200, 0, 0, 0, 0, 100, 0}};
        int   z[8] = '{default: 0};
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, vecs[i], 1'b1);
            @(negedge clk);
        end
        set_in(1'b0, z, 1'b1);
        repeat (4) @(negedge clk);
        n_vec++;
        if (sat_count !== 16'd3) begin
            n_err++;
            $display("FAIL sat_count: got %0d want 3", sat_count);
        end
        force dut.sat_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.sat_cnt;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, vecs[0], 1'b1);
            @(negedge clk);
        end
        set_in(1'b0, z, 1'b1);
        repeat (4) @(negedge clk);
        n_vec++;
        if (sat_count !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_count_max: got %h want ffff", sat_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_async_reset();
`ifdef DCT_INV_SAT_CNT_EN
        test_sat_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
